// File: rtl/sr_cmd_sequencer.sv
// Debounced set/clear command sequencer driving a gated SR latch with
// non-overlapping s/r pulses. Optional macro: SR_SKIP_REDUNDANT_EN.
module sr_cmd_sequencer #(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GUARD_CYCLES = 1,
  parameter int PRIO_SET     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       latch_en,
  output logic       busy,
  output logic       shadow_q,
  output logic       conflict,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam logic [3:0] DEB_LIM   = 4'(DEB_CYCLES);
  localparam logic [3:0] PULSE_END = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GUARD_END = 4'(GUARD_CYCLES - 1);
  localparam logic       PRIO_BIT  = (PRIO_SET != 0);

  state_e     state_q, state_d;
  logic [3:0] set_cnt_q, set_cnt_d, clr_cnt_q, clr_cnt_d;
  logic       set_deb_q, set_deb_d, clr_deb_q, clr_deb_d;
  logic       pend_set_q, pend_set_d, pend_clr_q, pend_clr_d;
  logic [3:0] tmr_q, tmr_d;
  logic       cmd_q, cmd_d;
  logic       s_q, s_d, r_q, r_d, en_q, en_d;
  logic       shadow_d, shadow_r;
  logic       conflict_q, conflict_d;

  logic       set_lvl, clr_lvl, set_qual, clr_qual;
  logic       set_eff, clr_eff, set_ok, clr_ok;

  // Saturating debounce counters; a request is the rising edge of the level.
  always_comb begin
    set_cnt_d = '0;
    clr_cnt_d = '0;
    if (set_req) set_cnt_d = (set_cnt_q == 4'hF) ? set_cnt_q : set_cnt_q + 4'd1;
    if (clr_req) clr_cnt_d = (clr_cnt_q == 4'hF) ? clr_cnt_q : clr_cnt_q + 4'd1;
    set_lvl   = (set_cnt_q >= DEB_LIM);
    clr_lvl   = (clr_cnt_q >= DEB_LIM);
    set_deb_d = set_lvl;
    clr_deb_d = clr_lvl;
    set_qual  = set_lvl & ~set_deb_q;
    clr_qual  = clr_lvl & ~clr_deb_q;
    set_eff   = pend_set_q | set_qual;
    clr_eff   = pend_clr_q | clr_qual;
`ifdef SR_SKIP_REDUNDANT_EN
    set_ok    = set_eff & ~shadow_r;
    clr_ok    = clr_eff & shadow_r;
`else
    set_ok    = set_eff;
    clr_ok    = clr_eff;
`endif
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cmd_d      = cmd_q;
    shadow_d   = shadow_r;
    conflict_d = 1'b0;
    pend_set_d = set_eff;
    pend_clr_d = clr_eff;
    unique case (state_q)
      ST_IDLE: begin
        // Every pending request is consumed here: issued, dropped or discarded.
        pend_set_d = 1'b0;
        pend_clr_d = 1'b0;
        if (set_ok || clr_ok) begin
          state_d    = ST_PULSE;
          tmr_d      = '0;
          cmd_d      = (set_ok && clr_ok) ? PRIO_BIT : set_ok;
          conflict_d = set_ok && clr_ok;
        end
      end
      ST_PULSE: begin
        if (tmr_q == PULSE_END) begin
          shadow_d = cmd_q;
          tmr_d    = '0;
          state_d  = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
        end else begin
          tmr_d = tmr_q + 4'd1;
        end
      end
      ST_GUARD: begin
        if (tmr_q == GUARD_END) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    en_d = (state_d == ST_PULSE);
    s_d  = en_d & cmd_d;
    r_d  = en_d & ~cmd_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      set_cnt_q  <= '0;
      clr_cnt_q  <= '0;
      set_deb_q  <= 1'b0;
      clr_deb_q  <= 1'b0;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      tmr_q      <= '0;
      cmd_q      <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      shadow_r   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      set_deb_q  <= set_deb_d;
      clr_deb_q  <= clr_deb_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      tmr_q      <= tmr_d;
      cmd_q      <= cmd_d;
      s_q        <= s_d;
      r_q        <= r_d;
      en_q       <= en_d;
      shadow_r   <= shadow_d;
      conflict_q <= conflict_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign latch_en  = en_q;
  assign busy      = (state_q != ST_IDLE);
  assign shadow_q  = shadow_r;
  assign conflict  = conflict_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer: drivers push expected pulse starts,
// a negedge monitor pops and compares. Honours SR_SKIP_REDUNDANT_EN.
module tb_sr_cmd_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic s, r, latch_en, busy, shadow_q, conflict;
  logic [1:0] state_dbg;
  logic p0_s, p0_r, p0_en, p0_busy, p0_shadow, p0_conflict;
  logic [1:0] p0_state;

  sr_cmd_sequencer #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .GUARD_CYCLES(1), .PRIO_SET(1)) dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .latch_en(latch_en), .busy(busy), .shadow_q(shadow_q),
    .conflict(conflict), .state_dbg(state_dbg)
  );

  sr_cmd_sequencer #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .GUARD_CYCLES(1), .PRIO_SET(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
    .s(p0_s), .r(p0_r), .latch_en(p0_en), .busy(p0_busy), .shadow_q(p0_shadow),
    .conflict(p0_conflict), .state_dbg(p0_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int conf_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  logic prev_on = 1'b0;
  int on_len = 0;
  int last_high = -1;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_on   = 1'b0;
      on_len    = 0;
      last_high = -1;
    end else begin
      check("s_r_exclusive", s & r, 0);
      check("latch_en_match", latch_en, s | r);
      if ((s | r) && !prev_on) begin
        if (last_high >= 0) check("guard_gap", (cyc - last_high - 1) >= 1, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got pulse s=%0d at cycle %0d expected none", s, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_start", {s, 15'(cyc)}, e);
        end
        on_len = 1;
      end else if (s | r) begin
        on_len++;
      end else if (prev_on) begin
        check("pulse_len", on_len, 2);
        last_high = cyc - 1;
      end
      if (conflict) begin
        if (conf_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_conflict: got conflict at cycle %0d expected none", cyc);
        end else begin
          check("conflict_cycle", cyc, conf_q.pop_front());
        end
      end
      prev_on = s | r;
    end
  end

  // driver tasks: inputs change just after the negedge sample point
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic push_cmd(input logic is_set, input int c);
    exp_q.push_back({is_set, 15'(c)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (3) tick();
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_latch_en", latch_en, 0);
    check("rst_busy", busy, 0);
    check("rst_shadow", shadow_q, 0);
    check("rst_conflict", conflict, 0);
    rst_n = 1'b1;
    tick();
  endtask

  int n;
  int pat[7] = '{1, 1, 0, 1, 1, 1, 1};
  logic saw_s0, saw_r0, saw_c0;

  initial begin
    // held set: pulse after edges n+4, n+5
    do_reset();
    n = cyc + 1;
    set_req = 1'b1;
    push_cmd(1'b1, n + 4);
    wait_to(n + 4);
    check("t1_s_on", s, 1);
    check("t1_en_on", latch_en, 1);
    check("t1_busy_pulse", busy, 1);
    wait_to(n + 5);
    check("t1_s_second", s, 1);
    wait_to(n + 6);
    check("t1_s_off", s, 0);
    check("t1_shadow", shadow_q, 1);
    check("t1_busy_guard", busy, 1);
    wait_to(n + 7);
    check("t1_busy_done", busy, 0);
    set_req = 1'b0;
    repeat (4) tick();

    // bouncing set: only the final 4-high run qualifies
    do_reset();
    n = cyc + 1;
    push_cmd(1'b1, n + 7);
    for (int i = 0; i < 7; i++) begin
      set_req = pat[i][0];
      tick();
    end
    set_req = 1'b0;
    repeat (12) tick();
    check("t2_shadow", shadow_q, 1);

    // simultaneous requests on both priority settings
    do_reset();
    n = cyc + 1;
    set_req = 1'b1;
    clr_req = 1'b1;
    push_cmd(1'b1, n + 4);
`ifndef SR_SKIP_REDUNDANT_EN
    conf_q.push_back(n + 4);
`endif
    saw_s0 = 1'b0;
    saw_r0 = 1'b0;
    saw_c0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw_s0 |= p0_s;
      saw_r0 |= p0_r;
      saw_c0 |= p0_conflict;
    end
    check("t3_shadow_prio1", shadow_q, 1);
`ifndef SR_SKIP_REDUNDANT_EN
    check("t3_shadow_prio0", p0_shadow, 0);
    check("t3_p0_r_seen", saw_r0, 1);
    check("t3_p0_s_seen", saw_s0, 0);
    check("t3_p0_conflict", saw_c0, 1);
`else
    check("t3_shadow_prio0", p0_shadow, 1);
    check("t3_p0_r_seen", saw_r0, 0);
    check("t3_p0_s_seen", saw_s0, 1);
    check("t3_p0_conflict", saw_c0, 0);
`endif
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (4) tick();

    // clear qualifies during the set pulse; served after GUARD and one IDLE cycle
    do_reset();
    n = cyc + 1;
    set_req = 1'b1;
    push_cmd(1'b1, n + 4);
    tick();
    clr_req = 1'b1;
    push_cmd(1'b0, n + 8);
    wait_to(n + 12);
    check("t4_shadow", shadow_q, 0);
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (4) tick();

    // reset in the middle of a pulse
    do_reset();
    n = cyc + 1;
    set_req = 1'b1;
    push_cmd(1'b1, n + 4);
    wait_to(n + 4);
    check("t5_s_before", s, 1);
    rst_n = 1'b0;
    set_req = 1'b0;
    tick();
    check("t5_s_rst", s, 0);
    check("t5_en_rst", latch_en, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_shadow_rst", shadow_q, 0);
    rst_n = 1'b1;
    repeat (12) tick();
    check("t5_shadow_after", shadow_q, 0);

    // two set requests in a row
    do_reset();
    n = cyc + 1;
    set_req = 1'b1;
    push_cmd(1'b1, n + 4);
`ifndef SR_SKIP_REDUNDANT_EN
    push_cmd(1'b1, n + 11);
`endif
    wait_to(n + 5);
    set_req = 1'b0;
    wait_to(n + 6);
    set_req = 1'b1;
    wait_to(n + 20);
    check("t6_shadow", shadow_q, 1);
    set_req = 1'b0;
    repeat (4) tick();

    check("exp_q_empty", exp_q.size(), 0);
    check("conf_q_empty", conf_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
